// File: rtl/backprop_batch_stack.sv
// Per-layer delta/activation store with a batched outer-product gradient accumulator.
// Gradients accumulate over a batch and are streamed out row by row, clearing as they go.
module backprop_batch_stack #(
  parameter int max_layer_size = 4,
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int frac_bits      = 8,
  parameter int batch_size     = 4,
  parameter int avg_shift      = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        store_en,
  input  logic [31:0]                 store_layer,
  input  logic [data_size*size-1:0]   delta_in,
  input  logic [data_size*size-1:0]   act_in,
  input  logic                        cal_dc_dw,
  input  logic [31:0]                 dc_dw_layer,
  input  logic                        dump_start,
  input  logic [31:0]                 dump_layer,
  output logic [data_size*size-1:0]   dc_dw_stream,
  output logic [31:0]                 dc_dw_row,
  output logic                        dc_dw_valid,
  output logic                        dc_dw_last,
  input  logic                        dc_dw_ready,
  output logic                        busy,
  output logic [max_layer_size-1:0]   batch_ready,
  output logic                        err,
  output logic [1:0]                  dbg_state
);

  localparam int LW = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
  localparam int RW = (size > 1) ? $clog2(size) : 1;
  localparam int CW = $clog2(batch_size + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(size - 1);
  localparam logic [CW-1:0] FULL     = CW'(batch_size);
  localparam logic signed [data_size-1:0]   MAXV = {1'b0, {(data_size-1){1'b1}}};
  localparam logic signed [data_size-1:0]   MINV = {1'b1, {(data_size-1){1'b0}}};
  localparam logic signed [2*data_size-1:0] MAXW = {{(data_size+1){1'b0}}, {(data_size-1){1'b1}}};
  localparam logic signed [2*data_size-1:0] MINW = {{(data_size+1){1'b1}}, {(data_size-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DUMP = 2'd2} state_e;

  state_e                       state_q, state_d;
  logic [LW-1:0]                layer_q, layer_d;
  logic [RW-1:0]                row_q, row_d;
  logic                         err_q, err_d;
  logic signed [data_size-1:0]  delta_mem_q [max_layer_size][size];
  logic signed [data_size-1:0]  delta_mem_d [max_layer_size][size];
  logic signed [data_size-1:0]  act_mem_q   [max_layer_size][size];
  logic signed [data_size-1:0]  act_mem_d   [max_layer_size][size];
  logic signed [data_size-1:0]  acc_q       [max_layer_size][size][size];
  logic signed [data_size-1:0]  acc_d       [max_layer_size][size][size];
  logic [CW-1:0]                count_q     [max_layer_size];
  logic [CW-1:0]                count_d     [max_layer_size];
  logic signed [data_size-1:0]  delta_snap_q [size];
  logic signed [data_size-1:0]  delta_snap_d [size];
  logic signed [data_size-1:0]  act_snap_q   [size];
  logic signed [data_size-1:0]  act_snap_d   [size];

  function automatic logic signed [data_size-1:0] sat(input logic signed [2*data_size-1:0] v);
    if (v > MAXW)      return MAXV;
    else if (v < MINW) return MINV;
    else               return v[data_size-1:0];
  endfunction

  function automatic logic signed [data_size-1:0] mac_step(
    input logic signed [data_size-1:0] acc,
    input logic signed [data_size-1:0] d,
    input logic signed [data_size-1:0] a
  );
    logic signed [2*data_size-1:0] prod;
    logic signed [2*data_size-1:0] term;
    logic signed [2*data_size-1:0] sum;
    prod = (2*data_size)'(d) * (2*data_size)'(a);
    term = (2*data_size)'(sat(prod >>> frac_bits));
    sum  = term + (2*data_size)'(acc);
    return sat(sum);
  endfunction

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    row_d        = row_q;
    err_d        = 1'b0;
    delta_mem_d  = delta_mem_q;
    act_mem_d    = act_mem_q;
    acc_d        = acc_q;
    count_d      = count_q;
    delta_snap_d = delta_snap_q;
    act_snap_d   = act_snap_q;

    if (store_en && (store_layer < max_layer_size)) begin
      for (int i = 0; i < size; i++) begin
        delta_mem_d[store_layer[LW-1:0]][i] = delta_in[(size-i)*data_size-1 -: data_size];
        act_mem_d[store_layer[LW-1:0]][i]   = act_in[(size-i)*data_size-1 -: data_size];
      end
    end

    case (state_q)
      IDLE: begin
        if (cal_dc_dw) begin
          // The pass works on a snapshot so stores during the pass cannot disturb it.
          if (dc_dw_layer >= max_layer_size) begin
            err_d = 1'b1;
          end else if (count_q[dc_dw_layer[LW-1:0]] == FULL) begin
            err_d = 1'b1;
          end else begin
            state_d      = CALC;
            layer_d      = dc_dw_layer[LW-1:0];
            row_d        = '0;
            delta_snap_d = delta_mem_q[dc_dw_layer[LW-1:0]];
            act_snap_d   = act_mem_q[dc_dw_layer[LW-1:0]];
          end
        end else if (dump_start) begin
          if (dump_layer >= max_layer_size) begin
            err_d = 1'b1;
          end else begin
            state_d = DUMP;
            layer_d = dump_layer[LW-1:0];
            row_d   = '0;
          end
        end
      end
      CALC: begin
        for (int c = 0; c < size; c++) begin
          acc_d[layer_q][row_q][c] = mac_step(acc_q[layer_q][row_q][c], delta_snap_q[row_q], act_snap_q[c]);
        end
        if (row_q == LAST_ROW) begin
          count_d[layer_q] = count_q[layer_q] + CW'(1);
          state_d          = IDLE;
          row_d            = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      DUMP: begin
        // Handshake: a row transfers on a cycle where dc_dw_valid and dc_dw_ready are both high;
        // while valid is high and ready low, row index and data stay frozen.
        if (dc_dw_ready) begin
          for (int c = 0; c < size; c++) acc_d[layer_q][row_q][c] = '0;
          if (row_q == LAST_ROW) begin
            count_d[layer_q] = '0;
            state_d          = IDLE;
            row_d            = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      layer_q      <= '0;
      row_q        <= '0;
      err_q        <= 1'b0;
      delta_mem_q  <= '{default: '0};
      act_mem_q    <= '{default: '0};
      acc_q        <= '{default: '0};
      count_q      <= '{default: '0};
      delta_snap_q <= '{default: '0};
      act_snap_q   <= '{default: '0};
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      row_q        <= row_d;
      err_q        <= err_d;
      delta_mem_q  <= delta_mem_d;
      act_mem_q    <= act_mem_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      delta_snap_q <= delta_snap_d;
      act_snap_q   <= act_snap_d;
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    dc_dw_valid  = (state_q == DUMP);
    dc_dw_last   = dc_dw_valid && (row_q == LAST_ROW);
    dc_dw_row    = dc_dw_valid ? 32'(row_q) : 32'd0;
    err          = err_q;
    dbg_state    = state_q;
    dc_dw_stream = '0;
    if (dc_dw_valid) begin
      for (int c = 0; c < size; c++) begin
        dc_dw_stream[(size-c)*data_size-1 -: data_size] = acc_q[layer_q][row_q][c] >>> avg_shift;
      end
    end
    batch_ready = '0;
    for (int l = 0; l < max_layer_size; l++) batch_ready[l] = (count_q[l] == FULL);
  end

endmodule

// File: tb/tb_backprop_batch_stack.sv
// Directed and random checks of backprop_batch_stack against an array-based gradient model.
// Two instances share stimulus: one with avg_shift=0, one with avg_shift=1.
module tb_backprop_batch_stack;
  localparam int L = 4;
  localparam int W = 16;
  localparam int N = 3;
  localparam int F = 8;
  localparam int B = 4;

  logic clk = 1'b0;
  logic reset;
  logic store_en;
  logic [31:0] store_layer;
  logic [W*N-1:0] delta_in, act_in;
  logic cal_dc_dw;
  logic [31:0] dc_dw_layer;
  logic dump_start;
  logic [31:0] dump_layer;
  logic dc_dw_ready;

  logic [W*N-1:0] stream0, stream1;
  logic [31:0] row0, row1;
  logic valid0, valid1, last0, last1, busy0, busy1, err0, err1;
  logic [L-1:0] br0, br1;
  logic [1:0] dbg0, dbg1;

  always #5 clk = ~clk;

  backprop_batch_stack #(.max_layer_size(L), .data_size(W), .size(N), .frac_bits(F),
                         .batch_size(B), .avg_shift(0)) dut0 (
    .clk(clk), .reset(reset), .store_en(store_en), .store_layer(store_layer),
    .delta_in(delta_in), .act_in(act_in), .cal_dc_dw(cal_dc_dw), .dc_dw_layer(dc_dw_layer),
    .dump_start(dump_start), .dump_layer(dump_layer), .dc_dw_stream(stream0), .dc_dw_row(row0),
    .dc_dw_valid(valid0), .dc_dw_last(last0), .dc_dw_ready(dc_dw_ready), .busy(busy0),
    .batch_ready(br0), .err(err0), .dbg_state(dbg0));

  backprop_batch_stack #(.max_layer_size(L), .data_size(W), .size(N), .frac_bits(F),
                         .batch_size(B), .avg_shift(1)) dut1 (
    .clk(clk), .reset(reset), .store_en(store_en), .store_layer(store_layer),
    .delta_in(delta_in), .act_in(act_in), .cal_dc_dw(cal_dc_dw), .dc_dw_layer(dc_dw_layer),
    .dump_start(dump_start), .dump_layer(dump_layer), .dc_dw_stream(stream1), .dc_dw_row(row1),
    .dc_dw_valid(valid1), .dc_dw_last(last1), .dc_dw_ready(dc_dw_ready), .busy(busy1),
    .batch_ready(br1), .err(err1), .dbg_state(dbg1));

  int vectors = 0;
  int miscompares = 0;

  int m_delta [L][N];
  int m_act   [L][N];
  int m_acc   [L][N][N];
  int m_cnt   [L];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*N-1:0] pack(input int v[N]);
    logic [W*N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[(N-i)*W-1 -: W] = W'(v[i]);
    return p;
  endfunction

  function automatic int sat(input longint v);
    longint maxv, minv;
    maxv = (longint'(1) <<< (W-1)) - 1;
    minv = -(longint'(1) <<< (W-1));
    if (v > maxv) return int'(maxv);
    if (v < minv) return int'(minv);
    return int'(v);
  endfunction

  function automatic logic [L-1:0] exp_br();
    logic [L-1:0] b;
    for (int l = 0; l < L; l++) b[l] = (m_cnt[l] == B);
    return b;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < L; l++) begin
      m_cnt[l] = 0;
      for (int r = 0; r < N; r++) begin
        m_delta[l][r] = 0;
        m_act[l][r] = 0;
        for (int c = 0; c < N; c++) m_acc[l][r][c] = 0;
      end
    end
  endtask

  task automatic model_store(input int l, input int d[N], input int a[N]);
    if (l < L) begin
      for (int i = 0; i < N; i++) begin
        m_delta[l][i] = d[i];
        m_act[l][i] = a[i];
      end
    end
  endtask

  // One full batch step: acc += saturated outer product delta x act.
  task automatic model_cal(input int l);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m_acc[l][r][c] = sat(longint'(m_acc[l][r][c]) +
                             longint'(sat((longint'(m_delta[l][r]) * longint'(m_act[l][c])) >>> F)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    store_en = 0; store_layer = 0; delta_in = '0; act_in = '0;
    cal_dc_dw = 0; dc_dw_layer = 0; dump_start = 0; dump_layer = 0; dc_dw_ready = 0;
  endtask

  task automatic rand_vec(output int v[N]);
    for (int i = 0; i < N; i++)
      v[i] = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 1024)) - 512;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_valid"}, valid0, 0);
    chk({tag, "_stream"}, stream0, 0);
    chk({tag, "_row"}, row0, 0);
    chk({tag, "_last"}, last0, 0);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_br"}, br0, exp_br());
  endtask

  task automatic do_store(input int l, input int d[N], input int a[N]);
    store_en = 1; store_layer = l; delta_in = pack(d); act_in = pack(a);
    tick();
    store_en = 0;
    model_store(l, d, a);
  endtask

  task automatic do_cal(input int l, input bit with_store, input int sl, input bit with_dump);
    int d[N], a[N];
    bit ok;
    rand_vec(d); rand_vec(a);
    ok = 0;
    if (l < L) ok = (m_cnt[l] != B);
    cal_dc_dw = 1; dc_dw_layer = l;
    if (with_dump) begin dump_start = 1; dump_layer = 0; end
    if (with_store) begin store_en = 1; store_layer = sl; delta_in = pack(d); act_in = pack(a); end
    tick();
    cal_dc_dw = 0; dump_start = 0; store_en = 0;
    if (ok) begin model_cal(l); m_cnt[l]++; end
    if (with_store) model_store(sl, d, a);
    if (ok) begin
      for (int k = 0; k < N; k++) begin
        chk("cal_busy", busy0, 1);
        chk("cal_err", err0, 0);
        chk("cal_valid", valid0, 0);
        cal_dc_dw = 1; dc_dw_layer = l;
        if (with_store) begin
          rand_vec(d); rand_vec(a);
          store_en = 1; store_layer = l; delta_in = pack(d); act_in = pack(a);
        end
        tick();
        if (with_store) model_store(l, d, a);
      end
      cal_dc_dw = 0; store_en = 0;
      chk("cal_done_busy", busy0, 0);
      chk("cal_done_err", err0, 0);
      chk("cal_done_valid", valid0, 0);
      chk("cal_done_br", br0, exp_br());
    end else begin
      chk("rej_err", err0, 1);
      chk("rej_busy", busy0, 0);
      tick();
      chk("rej_err_clr", err0, 0);
      chk("rej_busy2", busy0, 0);
    end
  endtask

  task automatic do_dump(input int l, input int stall[N]);
    int rowv[N], rowh[N];
    dump_start = 1; dump_layer = l;
    tick();
    dump_start = 0;
    if (l >= L) begin
      chk("dump_rej_err", err0, 1);
      chk("dump_rej_valid", valid0, 0);
      tick();
      chk("dump_rej_err_clr", err0, 0);
      return;
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        rowv[c] = m_acc[l][r][c];
        rowh[c] = m_acc[l][r][c] >>> 1;
      end
      for (int s = 0; s <= stall[r]; s++) begin
        chk("dump_valid", valid0, 1);
        chk("dump_busy", busy0, 1);
        chk("dump_row", row0, r);
        chk("dump_data", stream0, pack(rowv));
        chk("dump_data_avg", stream1, pack(rowh));
        chk("dump_last", last0, (r == N-1));
        dc_dw_ready = (s == stall[r]);
        tick();
      end
      for (int c = 0; c < N; c++) m_acc[l][r][c] = 0;
    end
    dc_dw_ready = 0;
    m_cnt[l] = 0;
    check_idle("dump_end");
  endtask

  initial begin
    int d[N], a[N], st[N], op, l;
    model_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    check_idle("reset");
    reset = 0;

    // Basic outer product on slot 1, then a double batch
    d = '{256, 512, -256}; a = '{256, 128, 0};
    do_store(1, d, a);
    do_cal(1, 0, 0, 0);
    st = '{0, 0, 0};
    do_dump(1, st);
    do_cal(1, 0, 0, 0);
    do_cal(1, 0, 0, 0);
    do_dump(1, st);

    // Saturation in both directions
    d = '{32767, 0, 0}; a = '{32767, 0, 0};
    do_store(0, d, a);
    do_cal(0, 0, 0, 0);
    do_cal(0, 0, 0, 0);
    do_dump(0, st);
    d = '{-32768, 0, 0};
    do_store(0, d, a);
    do_cal(0, 0, 0, 0);
    do_cal(0, 0, 0, 0);
    do_dump(0, st);

    // Backpressure on row 1
    d = '{100, -200, 300}; a = '{-50, 60, 70};
    do_store(3, d, a);
    do_cal(3, 0, 0, 0);
    st = '{0, 3, 0};
    do_dump(3, st);

    // Rejections: bad layer, full slot, bad dump layer
    do_cal(4, 0, 0, 0);
    for (int k = 0; k < B; k++) do_cal(0, 0, 0, 0);
    chk("full_br0", br0[0], 1);
    do_cal(0, 0, 0, 0);
    st = '{0, 0, 0};
    do_dump(0, st);
    do_dump(4, st);

    // Cal and dump together: cal wins; concurrent store not seen by the pass
    rand_vec(d); rand_vec(a);
    do_store(2, d, a);
    do_cal(2, 1, 2, 1);
    do_dump(2, st);

    // Reset in the middle of a dump
    rand_vec(d); rand_vec(a);
    do_store(2, d, a);
    do_cal(2, 0, 0, 0);
    dump_start = 1; dump_layer = 2;
    tick();
    dump_start = 0; dc_dw_ready = 1;
    tick();
    dc_dw_ready = 0;
    chk("mid_dump_row", row0, 1);
    reset = 1; cal_dc_dw = 1; dc_dw_layer = 2; store_en = 1; store_layer = 2;
    delta_in = pack(d); act_in = pack(a);
    tick();
    reset = 0;
    idle_inputs();
    model_reset();
    check_idle("after_reset");
    chk("after_reset_br1", br1, 0);
    chk("after_reset_err1", err1, 0);
    do_dump(2, st);
    do_cal(2, 0, 0, 0);
    do_dump(2, st);

    // Randomised mix of operations
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 2);
      l = $urandom_range(0, L);
      if (op == 0) begin
        rand_vec(d); rand_vec(a);
        do_store(l, d, a);
      end else if (op == 1) begin
        do_cal(l, 1, $urandom_range(0, L-1), 0);
      end else begin
        for (int i = 0; i < N; i++) st[i] = $urandom_range(0, 2);
        do_dump(l, st);
      end
    end
    for (int k = 0; k < L; k++) begin
      st = '{1, 0, 2};
      do_dump(k, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
